async_channel_arbiter: RTL

Shares one asynchronous 4-phase req/ack output channel among `NUM_REQ` synchronous ready/valid requesters, using round-robin arbitration. It sits between several clocked producers and a single self-timed consumer. It sequences the full return-to-zero handshake: raise req, wait for ack, drop req, wait for ack release. A watchdog flags a consumer that never acknowledges.

---
 rtl/async_channel_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/async_channel_arbiter.sv
// rtl/async_channel_arbiter.sv - round-robin share of one 4-phase req/ack channel
// Synchronous ready/valid requesters in, one return-to-zero async handshake out, with ack watchdog.
module async_channel_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int SYNC_STAGE = 2,
   parameter int TIMEOUT    = 255,
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            sync_valid,
   output logic [NUM_REQ-1:0]            sync_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] sync_d,
   output logic                          async_req,
   input  logic                          async_ack,
   output logic [DATA_WIDTH-1:0]         async_d,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic                          busy,
   output logic                          err_timeout,
   input  logic                          err_clear
);

   localparam int WD_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int CW       = ID_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

   state_t                state;
   logic [SYNC_STAGE-1:0] sync_ff;
   logic                  ack_s;
   logic [ID_WIDTH-1:0]   rr_ptr;
   logic [ID_WIDTH-1:0]   pick_idx;
   logic [ID_WIDTH-1:0]   next_ptr;
   logic                  pick_found;
   logic [CW-1:0]         cand;
   logic [WD_WIDTH-1:0]   wd_cnt;
   logic                  wd_expire;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_ff <= '0;
      end else begin
         sync_ff[0] <= async_ack;
         for (int i = 1; i < SYNC_STAGE; i++) begin
            sync_ff[i] <= sync_ff[i-1];
         end
      end
   end

   assign ack_s = sync_ff[SYNC_STAGE-1];

   // First set valid at or above rr_ptr, wrapping past NUM_REQ-1.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, rr_ptr} + CW'(i);
         if (cand >= CW'(NUM_REQ)) begin
            cand = cand - CW'(NUM_REQ);
         end
         if (!pick_found && sync_valid[cand[ID_WIDTH-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[ID_WIDTH-1:0];
         end
      end
   end

   assign next_ptr  = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
   // Abort on the TIMEOUT-th cycle spent in REQ_HI without an ack.
   assign wd_expire = (TIMEOUT != 0) && ((32'(wd_cnt) + 1) == TIMEOUT);

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         busy        <= 1'b0;
         async_req   <= 1'b0;
         async_d     <= '0;
         grant_id    <= '0;
         rr_ptr      <= '0;
         wd_cnt      <= '0;
         sync_ready  <= '0;
         err_timeout <= 1'b0;
      end else begin
         sync_ready <= '0;
         if (err_clear) begin
            err_timeout <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (!ack_s && pick_found) begin
                  grant_id  <= pick_idx;
                  async_d   <= sync_d[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                  async_req <= 1'b1;
                  wd_cnt    <= '0;
                  busy      <= 1'b1;
                  state     <= REQ_HI;
               end
            end
            REQ_HI: begin
               if (ack_s) begin
                  sync_ready[grant_id] <= 1'b1;
                  async_req            <= 1'b0;
                  rr_ptr               <= next_ptr;
                  state                <= REQ_LO;
               end else if (wd_expire) begin
                  err_timeout <= 1'b1;
                  async_req   <= 1'b0;
                  rr_ptr      <= next_ptr;
                  state       <= REQ_LO;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            REQ_LO: begin
               if (!ack_s) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               async_req <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
